// File: rtl/taillight_sequencer.sv
// Tail-light sequencer: prescaled step FSM driving three-lamp left/right turn sequences,
// hazard blink and brake override.
module taillight_sequencer #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    input  logic       H,
    input  logic       B,
    output logic       LC,
    output logic       LB,
    output logic       LA,
    output logic       RA,
    output logic       RB,
    output logic       RC,
    output logic [2:0] y,
    output logic       tick
);

    typedef enum logic [2:0] {
        StIdle = 3'b000,
        StL1   = 3'b001,
        StL2   = 3'b010,
        StL3   = 3'b011,
        StR1   = 3'b100,
        StR2   = 3'b101,
        StR3   = 3'b110,
        StHaz  = 3'b111
    } state_e;

    localparam logic [7:0] CntMax = 8'(TICK_DIV - 1);

    state_e     r_state;
    state_e     w_state_d;
    logic [7:0] r_cnt;
    logic       r_b_q;
    logic       w_tick;
    logic       w_hz;
    logic [2:0] w_left;
    logic [2:0] w_right;

    assign w_tick = (r_cnt == CntMax);
    assign w_hz   = H | (L & R);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 8'd0;
            r_b_q   <= 1'b0;
            r_state <= StIdle;
        end else begin
            r_cnt   <= w_tick ? 8'd0 : r_cnt + 8'd1;
            r_b_q   <= B;
            r_state <= w_state_d;
        end
    end

    // Sequences run to completion regardless of L/R; only hz can cut them short.
    always_comb begin
        w_state_d = r_state;
        if (w_tick) begin
            unique case (r_state)
                StIdle: begin
                    if (w_hz)   w_state_d = StHaz;
                    else if (L) w_state_d = StL1;
                    else if (R) w_state_d = StR1;
                end
                StL1:    w_state_d = w_hz ? StHaz : StL2;
                StL2:    w_state_d = w_hz ? StHaz : StL3;
                StL3:    w_state_d = w_hz ? StHaz : StIdle;
                StR1:    w_state_d = w_hz ? StHaz : StR2;
                StR2:    w_state_d = w_hz ? StHaz : StR3;
                StR3:    w_state_d = w_hz ? StHaz : StIdle;
                StHaz:   w_state_d = StIdle;
                default: w_state_d = StIdle;
            endcase
        end
    end

    // A side that is not sequencing shows the registered brake level.
    always_comb begin
        w_left  = r_b_q ? 3'b111 : 3'b000;
        w_right = r_b_q ? 3'b111 : 3'b000;
        unique case (r_state)
            StL1:    w_left  = 3'b001;
            StL2:    w_left  = 3'b011;
            StL3:    w_left  = 3'b111;
            StR1:    w_right = 3'b100;
            StR2:    w_right = 3'b110;
            StR3:    w_right = 3'b111;
            StHaz: begin
                w_left  = 3'b111;
                w_right = 3'b111;
            end
            default: ;
        endcase
    end

    assign {LC, LB, LA} = w_left;
    assign {RA, RB, RC} = w_right;
    assign y            = r_state;
    assign tick         = w_tick;

endmodule

// File: tb/tb_taillight_sequencer.sv
// Randomized scoreboard bench for taillight_sequencer against a behavioural lamp model.
module tb_taillight_sequencer;

    localparam int TD     = 4;
    localparam int NCYC   = 4000;

    logic clk = 1'b0;
    logic reset, L, R, H, B;
    logic LC, LB, LA, RA, RB, RC;
    logic [2:0] y;
    logic tick;

    taillight_sequencer #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .L     (L),
        .R     (R),
        .H     (H),
        .B     (B),
        .LC    (LC),
        .LB    (LB),
        .LA    (LA),
        .RA    (RA),
        .RB    (RB),
        .RC    (RC),
        .y     (y),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    // Expected {y, LC LB LA, RA RB RC, tick} per cycle, tagged with cycle number.
    typedef struct packed {
        int         cyc;
        logic [9:0] v;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_err    = 0;
    int pushed   = 0;

    // Model: side 0 none / 1 left / 2 right, step 1..3 lamps lit, haz blink phase.
    int m_cnt, m_side, m_step;
    bit m_haz, m_bq;

    function automatic logic [9:0] model_out();
        int ly, lft, rgt;
        if (m_haz) begin
            ly = 7; lft = 7; rgt = 7;
        end else begin
            ly  = (m_side == 1) ? m_step : (m_side == 2) ? 3 + m_step : 0;
            lft = (m_side == 1) ? (1 << m_step) - 1 : (m_bq ? 7 : 0);
            rgt = (m_side == 2) ? ((7 << (3 - m_step)) & 7) : (m_bq ? 7 : 0);
        end
        return {3'(ly), 3'(lft), 3'(rgt), (m_cnt == TD - 1)};
    endfunction

    task automatic model_edge();
        bit t, hz;
        if (reset) begin
            m_cnt = 0; m_side = 0; m_step = 0; m_haz = 0; m_bq = 0;
        end else begin
            t     = (m_cnt == TD - 1);
            m_cnt = (m_cnt + 1) % TD;
            m_bq  = B;
            if (t) begin
                hz = H | (L & R);
                if (m_haz) m_haz = 0;
                else if (hz) begin
                    m_haz = 1; m_side = 0; m_step = 0;
                end else if (m_side != 0) begin
                    m_step++;
                    if (m_step == 4) begin
                        m_side = 0; m_step = 0;
                    end
                end else if (L) begin
                    m_side = 1; m_step = 1;
                end else if (R) begin
                    m_side = 2; m_step = 1;
                end
            end
        end
    endtask

    // Monitor: outputs are valid every cycle once the first edge has been modelled.
    initial begin
        exp_t       e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {y, LC, LB, LA, RA, RB, RC, tick};
                n_checks++;
                if (act !== e.v) begin
                    n_err++;
                    $display("FAIL outputs cycle %0d: got y=%b L=%b R=%b tick=%b, want y=%b L=%b R=%b tick=%b",
                             e.cyc, act[9:7], act[6:4], act[3:1], act[0],
                             e.v[9:7], e.v[6:4], e.v[3:1], e.v[0]);
                end
            end
        end
    end

    initial begin
        int seg;
        reset = 1'b1; L = 1'b0; R = 1'b0; H = 1'b0; B = 1'b0;
        seg = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc >= 2) begin
                if (seg == 0) begin
                    // Held levels so sequences complete; short segments give between-tick pulses.
                    seg = $urandom_range(1, 24);
                    L   = ($urandom_range(0, 99) < 40);
                    R   = ($urandom_range(0, 99) < 35);
                    H   = ($urandom_range(0, 99) < 10);
                    B   = ($urandom_range(0, 99) < 30);
                end
                seg--;
                reset = ($urandom_range(0, 149) == 0);
            end
            @(posedge clk);
            model_edge();
            sb.push_back('{cyc: cyc, v: model_out()});
            pushed++;
            #1;
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0 || n_checks != pushed + 1) begin
            n_err++;
            $display("FAIL drain: got %0d left, %0d checked, want 0 left, %0d checked",
                     sb.size(), n_checks - 1, pushed);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/taillight_sequencer.md
TAILLIGHT_SEQUENCER -- requirements
Module: taillight_sequencer

Interface
REQ-001 Parameter: TICK_DIV, 4, clock cycles per lamp step; legal range is 2 to 255.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: L  input  1  left-turn request, level-sensitive.
REQ-005 Port: R  input  1  right-turn request, level-sensitive.
REQ-006 Port: H  input  1  hazard request, level-sensitive.
REQ-007 Port: B  input  1  brake request, level-sensitive.
REQ-008 Port: LC, LB, LA  output  1 each  left lamps, outer to inner.
REQ-009 Port: RA, RB, RC  output  1 each  right lamps, inner to outer.
REQ-010 Port: y  output  3  current state encoding.
REQ-011 Port: tick  output  1  step strobe.

Function
REQ-012 Prescaler counter cnt SHALL count 0..TICK_DIV-1 every cycle and wrap to 0.
REQ-013 tick SHALL be 1 exactly in cycles where cnt == TICK_DIV-1.
REQ-014 The FSM SHALL change state only on edges where tick == 1.
REQ-015 FSM state encoding SHALL be: IDLE=000, L1=001, L2=010, L3=011, R1=100, R2=101, R3=110, HAZ=111.
REQ-016 Derived term hz = H | (L & R), evaluated only at tick.
REQ-017 IDLE transitions at tick SHALL be, in priority order: hz -> HAZ; else L -> L1; else R -> R1; else stay IDLE.
REQ-018 L1->L2->L3->IDLE and R1->R2->R3->IDLE SHALL advance on every tick, independent of L/R, so a started sequence always completes.
REQ-019 hz at any tick in L1..L3 or R1..R3 SHALL pre-empt to HAZ.
REQ-020 HAZ SHALL return to IDLE at the next tick, giving a 50% blink while hz persists.
REQ-021 Inputs that are active only between ticks SHALL have no effect.
REQ-022 Left lamps LC LB LA SHALL be 001 in L1, 011 in L2, 111 in L3, and 000 otherwise, except as overridden by REQ-024/025.
REQ-023 Right lamps RA RB RC SHALL be 100 in R1, 110 in R2, 111 in R3, and 000 otherwise, except as overridden by REQ-024/025.
REQ-024 In HAZ, all six lamps SHALL be 1.
REQ-025 B SHALL be registered every cycle into b_q; when b_q=1, every side not currently sequencing SHALL show 111.
REQ-026 In IDLE with b_q=1, all six lamps SHALL be 1.
REQ-027 Brake latency SHALL be one cycle: lamps reflect B one edge after B changes.
REQ-028 Lamps SHALL be a Moore function of (state, b_q) only, with no combinational path from L, R, H or B.

Reset
REQ-029 When reset=1 at a rising edge, state SHALL become IDLE, cnt 0, and b_q 0.
REQ-030 In the cycle after a reset edge, all lamps SHALL be 0, y SHALL be 000, and tick SHALL be 0.
REQ-031 Reset SHALL take priority over tick and all requests, including mid-sequence and in HAZ.
REQ-032 After reset is released, the first tick SHALL occur TICK_DIV cycles later.

Verification (TICK_DIV=4)
REQ-033 Scenario: reset high 2 cycles, then released with all inputs 0 -> lamps 000000, y=000, and tick first high in the 4th cycle after release, then every 4 cycles.
REQ-034 Scenario: L held 1 -> y on successive ticks is 001, 010, 011, 000, 001; LC LB LA is 001, 011, 111, 000; right lamps stay 000.
REQ-035 Scenario: L held, R raised while y=010 -> next tick y=111 with all lamps 1; following tick y=000 with all lamps 0; alternation continues while both are held.
REQ-036 Scenario: R held and B=1 from cycle n -> left lamps 111 from cycle n+1; RA RB RC steps 100, 110, 111; with B=0 and y=000, all lamps 0.
REQ-037 Scenario: reset pulsed 1 cycle while y=010 -> next cycle y=000, lamps 000000, cnt=0, and no tick for 3 cycles.
REQ-038 Scenario: L pulsed 1 cycle with cnt=1 -> y stays 000 and lamps stay 0.
